// File: rtl/omsp_spm_key_writer.sv
// omsp_spm_key_writer: packs the key-derivation byte stream into 16-bit words and writes them
// into the SPM key storage in index order, first byte of each word in the high half.
// A violation (abort) during a load discards the partially packed word and sets a sticky error.
module omsp_spm_key_writer #(
  parameter int SECURITY     = 64,
  parameter int KEY_IDX_SIZE = 2
) (
  input  logic                    mclk,
  input  logic                    puc_rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [7:0]              byte_in,
  input  logic                    byte_valid,
  output logic                    byte_ready,
  output logic                    write_key,
  output logic [15:0]             key_in,
  output logic [KEY_IDX_SIZE-1:0] key_idx,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam int NB_WORDS = SECURITY / 16;
  localparam logic [KEY_IDX_SIZE-1:0] LAST_IDX = KEY_IDX_SIZE'(NB_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HI    = 3'd1,
    S_LO    = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [KEY_IDX_SIZE-1:0] r_word_cnt;
  logic [7:0]              r_word_hi;
  logic [7:0]              r_word_lo;
  logic [15:0]             r_key_hold;
  logic [KEY_IDX_SIZE-1:0] r_idx_hold;
  logic                    r_error;

  logic w_xfer;
  logic w_start_ok;
  logic w_last;

  assign w_xfer     = byte_ready & byte_valid;
  assign w_start_ok = (r_state == S_IDLE) & start & ~abort;
  assign w_last     = (r_word_cnt == LAST_IDX);

  // State register; an asynchronous reset drops any load in flight without side effects.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and strobe decode; abort outranks every transfer, write and done.
  always_comb begin
    w_state_nxt = r_state;
    byte_ready  = 1'b0;
    write_key   = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) w_state_nxt = S_HI;
      end
      S_HI: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          byte_ready = 1'b1;
          if (byte_valid) w_state_nxt = S_LO;
        end
      end
      S_LO: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          byte_ready = 1'b1;
          if (byte_valid) w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          write_key   = 1'b1;
          w_state_nxt = w_last ? S_DONE : S_HI;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        if (!abort) done = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Byte packing, word counter, held output word and sticky error flag.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      r_word_cnt <= '0;
      r_word_hi  <= 8'h00;
      r_word_lo  <= 8'h00;
      r_key_hold <= 16'h0000;
      r_idx_hold <= '0;
      r_error    <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_word_cnt <= '0;
        r_error    <= 1'b0;
      end
      if (abort && (r_state != S_IDLE)) r_error <= 1'b1;
      if ((r_state == S_HI) && w_xfer) r_word_hi <= byte_in;
      if ((r_state == S_LO) && w_xfer) r_word_lo <= byte_in;
      if (write_key) begin
        r_key_hold <= {r_word_hi, r_word_lo};
        r_idx_hold <= r_word_cnt;
        // The counter stops on the last index so it never wraps within a load.
        if (!w_last) r_word_cnt <= r_word_cnt + 1'b1;
      end
    end
  end

  assign key_in  = write_key ? {r_word_hi, r_word_lo} : r_key_hold;
  assign key_idx = write_key ? r_word_cnt : r_idx_hold;
  assign busy    = (r_state != S_IDLE);
  assign error   = r_error;

endmodule

// File: tb/tb_omsp_spm_key_writer.sv
// Bench for omsp_spm_key_writer: a timeline model of each key load predicts the cycle and content
// of every key write and done pulse; a monitor pops those predictions as the DUT emits events.
module tb_omsp_spm_key_writer;

  logic mclk = 1'b0;
  always #5 mclk = ~mclk;

  logic        puc_rst;
  logic        start, abort, byte_valid;
  logic [7:0]  byte_in;
  logic        byte_ready, write_key, busy, done, error;
  logic [15:0] key_in;
  logic [1:0]  key_idx;

  logic        s_start, s_abort, s_byte_valid;
  logic [7:0]  s_byte_in;
  logic        s_byte_ready, s_write_key, s_busy, s_done, s_error;
  logic [15:0] s_key_in;
  logic [0:0]  s_key_idx;

  omsp_spm_key_writer #(.SECURITY(64), .KEY_IDX_SIZE(2)) u_dut (
    .mclk(mclk), .puc_rst(puc_rst), .start(start), .abort(abort),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .write_key(write_key), .key_in(key_in), .key_idx(key_idx),
    .busy(busy), .done(done), .error(error)
  );

  omsp_spm_key_writer #(.SECURITY(16), .KEY_IDX_SIZE(1)) u_dut16 (
    .mclk(mclk), .puc_rst(puc_rst), .start(s_start), .abort(s_abort),
    .byte_in(s_byte_in), .byte_valid(s_byte_valid), .byte_ready(s_byte_ready),
    .write_key(s_write_key), .key_in(s_key_in), .key_idx(s_key_idx),
    .busy(s_busy), .done(s_done), .error(s_error)
  );

  localparam int NW = 4;

  typedef struct {
    bit          is_done;
    int          idx;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  typedef struct {
    bit         v;
    logic [7:0] b;
    bit         ab;
    bit         st;
    bit         rst;
    bit         rdy;
  } slot_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;

  always @(posedge mclk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic slot_t mk(input bit v, input logic [7:0] b, input bit ab, input bit rdy);
    slot_t s;
    s.v = v; s.b = b; s.ab = ab; s.st = 1'b0; s.rst = 1'b0; s.rdy = rdy;
    return s;
  endfunction

  // Monitor: every write or done the DUT presents must match the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge mclk);
      #3;
      if (write_key || done) begin
        if (sb.size() == 0) begin
          chk("unexpected_event", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("event_kind", done, e.is_done);
          chk("event_cycle", cyc, e.cyc);
          if (!e.is_done) begin
            chk("key_idx", key_idx, e.idx);
            chk("key_in", key_in, e.data);
          end
        end
      end
    end
  end

  // kind: 0 clean load, 1 abort on byte pos, 2 abort in WRITE of word pos,
  //       3 abort in DONE, 4 asynchronous reset while byte pos is offered.
  task automatic run_load(input bit seq, input int gmax, input int kind, input int pos,
                          input bit extra_start, input int gap_byte, input int gap_len);
    logic [7:0] key [2*NW];
    slot_t      plan [$];
    exp_t       pend [$];
    exp_t       e;
    slot_t      s;
    int         g, j, t0, k;
    bit         stop;
    for (int i = 0; i < 2*NW; i++) key[i] = seq ? 8'(i + 1) : 8'($urandom);
    s = mk(1'b1, 8'($urandom), 1'b0, 1'b0);
    s.st = 1'b1;
    plan.push_back(s);
    stop = 1'b0;
    k = 0;
    while (k < NW && !stop) begin
      for (int h = 0; h < 2 && !stop; h++) begin
        j = 2*k + h;
        g = (j == gap_byte) ? gap_len : ((gmax > 0) ? int'($urandom_range(0, gmax)) : 0);
        repeat (g) plan.push_back(mk(1'b0, 8'($urandom), 1'b0, 1'b1));
        if ((kind == 1 || kind == 4) && pos == j) begin
          s = mk(1'b1, key[j], kind == 1, kind == 4);
          s.rst = (kind == 4);
          plan.push_back(s);
          stop = 1'b1;
        end else begin
          plan.push_back(mk(1'b1, key[j], 1'b0, 1'b1));
        end
      end
      if (!stop) begin
        if (kind == 2 && pos == k) begin
          plan.push_back(mk(1'b1, 8'($urandom), 1'b1, 1'b0));
          stop = 1'b1;
        end else begin
          e.is_done = 1'b0; e.idx = k; e.data = {key[2*k], key[2*k+1]}; e.cyc = plan.size();
          pend.push_back(e);
          plan.push_back(mk(1'b1, 8'($urandom), 1'b0, 1'b0));
        end
      end
      k++;
    end
    if (!stop) begin
      if (kind == 3) begin
        plan.push_back(mk(1'b1, 8'($urandom), 1'b1, 1'b0));
      end else begin
        e.is_done = 1'b1; e.idx = 0; e.data = 16'h0; e.cyc = plan.size();
        pend.push_back(e);
        plan.push_back(mk(1'b1, 8'($urandom), 1'b0, 1'b0));
      end
    end
    if (extra_start && plan.size() > 2) plan[$urandom_range(1, plan.size() - 1)].st = 1'b1;

    @(negedge mclk);
    t0 = cyc;
    foreach (pend[i]) begin
      e = pend[i];
      e.cyc = t0 + e.cyc;
      sb.push_back(e);
    end
    foreach (plan[i]) begin
      if (i > 0) @(negedge mclk);
      start = plan[i].st; abort = plan[i].ab; byte_valid = plan[i].v; byte_in = plan[i].b;
      #1;
      if (plan[i].rst) begin
        puc_rst = 1'b1;
        #1;
        chk("rst_byte_ready", byte_ready, 0);
        chk("rst_write_key", write_key, 0);
        chk("rst_key_in", key_in, 0);
        chk("rst_key_idx", key_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
      end else begin
        chk("byte_ready", byte_ready, plan[i].rdy);
        if (i == 1) begin
          chk("busy_after_start", busy, 1);
          chk("error_cleared", error, 0);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge mclk);
      puc_rst = 1'b0;
      start = 1'b0; abort = 1'b0; byte_valid = 1'b1; byte_in = 8'($urandom);
      #1;
      chk("idle_byte_ready", byte_ready, 0);
      chk("idle_busy", busy, 0);
    end
    chk("error_after_load", error, (kind >= 1 && kind <= 3) ? 1 : 0);
    chk("scoreboard_drained", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    puc_rst = 1'b1;
    start = 1'b0; abort = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    s_start = 1'b0; s_abort = 1'b0; s_byte_valid = 1'b0; s_byte_in = 8'h00;
    repeat (3) @(negedge mclk);
    chk("reset_byte_ready", byte_ready, 0);
    chk("reset_write_key", write_key, 0);
    chk("reset_key_in", key_in, 0);
    chk("reset_key_idx", key_idx, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_error", error, 0);
    chk("reset16_busy", s_busy, 0);
    puc_rst = 1'b0;
    repeat (2) @(negedge mclk);

    // Bytes 01..08 streamed back to back, then the same stream stalled before byte 03.
    run_load(1'b1, 0, 0, 0, 1'b0, -1, 0);
    run_load(1'b1, 0, 0, 0, 1'b0, 2, 5);

    // Abort in the second WRITE, start+abort in IDLE keeps error, then a clean reload.
    run_load(1'b0, 0, 2, 1, 1'b0, -1, 0);
    @(negedge mclk);
    start = 1'b1; abort = 1'b1; byte_valid = 1'b1;
    @(negedge mclk);
    start = 1'b0; abort = 1'b0;
    #1;
    chk("start_abort_idle_busy", busy, 0);
    chk("start_abort_idle_error", error, 1);
    run_load(1'b0, 1, 0, 0, 1'b0, -1, 0);

    // Restart attempts during a load, then an asynchronous reset with the low byte pending.
    run_load(1'b0, 2, 0, 0, 1'b1, -1, 0);
    run_load(1'b0, 0, 4, 1, 1'b0, -1, 0);

    // Abort in HI/LO, WRITE and DONE, plus clean loads, with random stalls and bytes.
    for (int n = 0; n < 24; n++) begin
      int kd;
      kd = int'($urandom_range(0, 3));
      run_load(1'b0, 3, kd, (kd == 1) ? int'($urandom_range(0, 2*NW - 1)) : int'($urandom_range(0, NW - 1)),
               1'($urandom), -1, 0);
    end

    // Single-word key: one write at index 0 in cycle 3, done in cycle 4, idle in cycle 5.
    @(negedge mclk);
    s_start = 1'b1; s_byte_valid = 1'b1; s_byte_in = 8'hAA;
    #1 chk("k16_ready_idle", s_byte_ready, 0);
    @(negedge mclk);
    s_start = 1'b0; s_byte_in = 8'h5A;
    #1 chk("k16_ready_hi", s_byte_ready, 1);
    @(negedge mclk);
    s_byte_in = 8'hC3;
    #1 chk("k16_ready_lo", s_byte_ready, 1);
    @(negedge mclk);
    s_byte_in = 8'h11;
    #1;
    chk("k16_write_key", s_write_key, 1);
    chk("k16_key_in", s_key_in, 16'h5AC3);
    chk("k16_key_idx", s_key_idx, 0);
    chk("k16_ready_write", s_byte_ready, 0);
    chk("k16_done_early", s_done, 0);
    @(negedge mclk);
    #1;
    chk("k16_done", s_done, 1);
    chk("k16_write_after", s_write_key, 0);
    chk("k16_ready_done", s_byte_ready, 0);
    chk("k16_busy_done", s_busy, 1);
    @(negedge mclk);
    #1;
    chk("k16_busy_end", s_busy, 0);
    chk("k16_done_end", s_done, 0);
    chk("k16_key_hold", s_key_in, 16'h5AC3);
    chk("k16_error", s_error, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
